// File: rtl/sar_adc_pkg.sv
// Shared definitions for the successive-approximation ADC controller.
//   sar_state_t   : controller state encoding
//   DEF_*         : default resolution and timing parameters
//   conv_latency  : cycles from accepted start to the edge that raises done
//   timer_width   : width of the shared SAMPLE/SETTLE down-counter
package sar_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  localparam int unsigned DEF_WIDTH         = 10;
  localparam int unsigned DEF_SAMPLE_CYCLES = 4;
  localparam int unsigned DEF_CMP_SETTLE    = 1;

  function automatic int unsigned conv_latency(input int unsigned width,
                                               input int unsigned sample_cycles,
                                               input int unsigned cmp_settle);
    return sample_cycles + width * (cmp_settle + 1);
  endfunction

  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  localparam int unsigned CONV_LATENCY =
    conv_latency(DEF_WIDTH, DEF_SAMPLE_CYCLES, DEF_CMP_SETTLE);

endpackage

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter with a zero flag, used to time the track window and
// the comparator settling window.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : counter is at zero (it stops there until reloaded)
module sar_cycle_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller. Tracks the input for SAMPLE_CYCLES,
// holds it, then resolves one bit per step MSB first by driving a trial code
// to the DAC and reading back the comparator.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : conversion request, accepted only in IDLE or DONE
//   cmp_in    : comparator, 1 = held input >= DAC(dac_code)
//   sh_hold   : sample/hold switch, 0 = track, 1 = hold
//   dac_code  : trial code to the DAC
//   busy      : conversion in progress
//   done      : one-cycle pulse when data_out updates
//   data_out  : last completed conversion result
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int unsigned CMP_SETTLE    = DEF_CMP_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sh_hold,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned TW = timer_width(SAMPLE_CYCLES, CMP_SETTLE);

  localparam logic [TW-1:0]    SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(CMP_SETTLE - 1);
  localparam logic [IW-1:0]    MSB_IDX     = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state;
  logic [IW-1:0]    bit_idx;
  logic             tmr_load;
  logic [TW-1:0]    tmr_load_val;
  logic             tmr_zero;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] next_trial;

  sar_cycle_timer #(
    .CW(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // Timer loads coincide with the state transitions that start a timed window.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = SETTLE_LOAD;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          tmr_load     = 1'b1;
          tmr_load_val = SAMPLE_LOAD;
        end
      end
      SAMPLE:  tmr_load = tmr_zero;
      DECIDE:  tmr_load = (bit_idx != '0);
      default: ;
    endcase
  end

  // Current bit is already 1 in the trial code; a low comparator clears it.
  always_comb begin
    resolved = dac_code;
    if (!cmp_in) begin
      resolved[bit_idx] = 1'b0;
    end
    next_trial = resolved;
    if (bit_idx != '0) begin
      next_trial[bit_idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      sh_hold  <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          if (tmr_zero) begin
            state    <= SETTLE;
            sh_hold  <= 1'b1;
            bit_idx  <= MSB_IDX;
            dac_code <= MSB_CODE;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (bit_idx != '0) begin
            dac_code <= next_trial;
            bit_idx  <= bit_idx - 1'b1;
            state    <= SETTLE;
          end else begin
            data_out <= resolved;
            done     <= 1'b1;
            sh_hold  <= 1'b0;
            busy     <= 1'b0;
            dac_code <= '0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with default parameters (10 bits, 4 track
// cycles, 1 settle cycle). A comparator model latches vin on the rising edge
// of sh_hold and compares it against dac_code.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_in;
  logic       sh_hold;
  logic [9:0] dac_code;
  logic       busy;
  logic       done;
  logic [9:0] data_out;

  logic [9:0] vin = '0;
  logic [9:0] vin_held = '0;
  logic       cmp_force_en = 1'b0;
  logic       cmp_force_val = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [9:0] dac_at4, dac_at6;
  logic       hold_at3, hold_at4;

  sar_adc_ctrl #(
    .WIDTH         (10),
    .SAMPLE_CYCLES (4),
    .CMP_SETTLE    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmp_in   (cmp_in),
    .sh_hold  (sh_hold),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge sh_hold) vin_held = vin;

  assign cmp_in = cmp_force_en ? cmp_force_val : (vin_held >= dac_code);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One conversion from IDLE. n counts edges after the accepting edge E0;
  // samples are taken 1 time unit after each edge.
  task automatic run_conv(input string tag, input logic [9:0] v,
                          input logic [9:0] exp, input bit mid_start,
                          input bit swap, input logic [9:0] swap_val,
                          input bit glitch);
    int  n;
    int  busy_cnt;
    bit  got;
    vin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (n < 100 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (n == 3) hold_at3 = sh_hold;
        if (n == 4) begin
          hold_at4 = sh_hold;
          dac_at4  = dac_code;
        end
        if (n == 6) dac_at6 = dac_code;
        if (swap && n == 4) vin = swap_val;
        if (mid_start) start = (n == 10);
        if (glitch) begin
          cmp_force_val = ~(vin_held >= dac_code);
          cmp_force_en  = (n >= 4) && (n <= 22) && (n % 2 == 0);
        end
        @(posedge clk); #1;
        n++;
      end
    end
    cmp_force_en = 1'b0;
    start        = 1'b0;
    check_eq({tag, "_latency"}, n, 24);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 24);
    check_eq({tag, "_data"}, data_out, exp);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_hold_at_done"}, sh_hold, 0);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int         n;
    int         viol;
    bit         prev_done;
    int         done_times[$];

    #12;
    check_eq("rst_hold", sh_hold, 0);
    check_eq("rst_dac", dac_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_data", data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero input, with trial-code sequence and hold timing.
    run_conv("v0", 10'd0, 10'h000, 1'b0, 1'b0, '0, 1'b0);
    check_eq("v0_hold_n3", hold_at3, 0);
    check_eq("v0_hold_n4", hold_at4, 1);
    check_eq("v0_trial0", dac_at4, 10'h200);
    check_eq("v0_trial1", dac_at6, 10'h100);

    run_conv("v1023", 10'd1023, 10'h3FF, 1'b0, 1'b0, '0, 1'b0);
    check_eq("v1023_trial1", dac_at6, 10'h300);
    repeat (3) @(posedge clk);
    #1;
    check_eq("data_hold_idle", data_out, 10'h3FF);

    run_conv("v512", 10'd512, 10'h200, 1'b0, 1'b0, '0, 1'b0);
    run_conv("v511", 10'd511, 10'h1FF, 1'b0, 1'b0, '0, 1'b0);
    run_conv("v341", 10'd341, 10'h155, 1'b1, 1'b0, '0, 1'b0);

    // Start held high: done every 25 cycles, each one cycle wide.
    vin   = 10'd341;
    start = 1'b1;
    @(posedge clk); #1;
    viol      = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 75; i++) begin
      if (done) done_times.push_back(i);
      if (done && prev_done) viol++;
      if (done && busy) viol++;
      if (!done && !busy) viol++;
      prev_done = done;
      if (i == 74) start = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq("cont_ndone", done_times.size(), 3);
    if (done_times.size() == 3) begin
      check_eq("cont_done0", done_times[0], 24);
      check_eq("cont_done1", done_times[1], 49);
      check_eq("cont_done2", done_times[2], 74);
    end
    check_eq("cont_viol", viol, 0);
    check_eq("cont_data", data_out, 10'h155);
    @(posedge clk); #1;
    check_eq("cont_stop_busy", busy, 0);
    @(posedge clk); #1;

    // Reset mid-conversion.
    run_conv("v700", 10'd700, 10'h2BC, 1'b0, 1'b0, '0, 1'b0);
    vin   = 10'd300;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_pre_busy", busy, 1);
    check_eq("abort_pre_hold", sh_hold, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_hold", sh_hold, 0);
    check_eq("abort_dac", dac_code, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_data", data_out, 0);
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check_eq("abort_no_done", n, 0);
    check_eq("abort_data_after", data_out, 0);
    run_conv("v300", 10'd300, 10'h12C, 1'b0, 1'b0, '0, 1'b0);

    // Input change after hold, and comparator glitches while settling.
    run_conv("vswap", 10'd100, 10'h064, 1'b0, 1'b1, 10'd900, 1'b0);
    run_conv("vglitch", 10'd100, 10'h064, 1'b0, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
